logic_unit_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multiplexer-built 2-input logic unit (NOT/OR/AND/NAND/NOR/XOR/XNOR, applied bitwise) among several requesters. Each requester presents an opcode and two operands with a request. The block grants one requester at a time, captures its operands, evaluates the operation through the shared unit, and returns a tagged, registered result. It sits between client blocks and the single gate datapath so that the datapath is never instantiated per client.

---
 rtl/logic_unit_arbiter.sv | 148 ++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one mux-built bitwise logic unit among NREQ requesters.
// Latency: grant 1 cycle after req is sampled, result 1 cycle later; one operation per 3 cycles, losers wait with req held.
module logic_unit_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int IDW  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [3*NREQ-1:0]   op,
   input  logic [W*NREQ-1:0]   a,
   input  logic [W*NREQ-1:0]   b,
   output logic [NREQ-1:0]     gnt,
   output logic [W-1:0]        res,
   output logic                res_valid,
   output logic [IDW-1:0]      res_id,
   output logic                res_err,
   output logic                busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_win;
   logic [2:0]       r_op;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic [NREQ-1:0]  r_gnt;
   logic [W-1:0]     r_res;
   logic             r_res_valid;
   logic [IDW-1:0]   r_res_id;
   logic             r_res_err;
   logic             r_busy;

   logic             w_found;
   logic [IDW-1:0]   w_win;
   logic [IDW-1:0]   w_idx;
   logic [W-1:0]     w_res;

   function automatic logic [IDW-1:0] f_wrap(input logic [IDW:0] v);
      if (v >= (IDW+1)'(NREQ))
         return IDW'(v - (IDW+1)'(NREQ));
      else
         return v[IDW-1:0];
   endfunction

   // Every gate is a 2:1 mux selected by a[k]; the opcode picks the two data inputs.
   function automatic logic [W-1:0] f_gate(input logic [2:0] opc,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
      logic [W-1:0] d0;
      logic [W-1:0] d1;
      logic [W-1:0] r;
      case (opc)
         3'd0:    begin d1 = '0;  d0 = '1;  end
         3'd1:    begin d1 = '1;  d0 = y;   end
         3'd2:    begin d1 = y;   d0 = '0;  end
         3'd3:    begin d1 = ~y;  d0 = '1;  end
         3'd4:    begin d1 = '0;  d0 = ~y;  end
         3'd5:    begin d1 = ~y;  d0 = y;   end
         3'd6:    begin d1 = y;   d0 = ~y;  end
         default: begin d1 = '0;  d0 = '0;  end
      endcase
      for (int k = 0; k < W; k++)
         r[k] = x[k] ? d1[k] : d0[k];
      return r;
   endfunction

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_idx = f_wrap({1'b0, r_ptr} + (IDW+1)'(i));
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_res = f_gate(r_op, r_a, r_b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_win       <= '0;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_gnt       <= '0;
         r_res       <= '0;
         r_res_valid <= 1'b0;
         r_res_id    <= '0;
         r_res_err   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_win   <= w_win;
                  r_op    <= op[3*w_win +: 3];
                  r_a     <= a[W*w_win +: W];
                  r_b     <= b[W*w_win +: W];
                  r_gnt   <= NREQ'(1) << w_win;
                  r_busy  <= 1'b1;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_gnt       <= '0;
               r_res       <= w_res;
               r_res_valid <= 1'b1;
               r_res_id    <= r_win;
               r_res_err   <= (r_op == 3'd7);
               r_state     <= S_RESP;
            end
            S_RESP: begin
               r_res_valid <= 1'b0;
               r_ptr       <= f_wrap({1'b0, r_win} + (IDW+1)'(1));
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_gnt       <= '0;
               r_res_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign res       = r_res;
   assign res_valid = r_res_valid;
   assign res_id    = r_res_id;
   assign res_err   = r_res_err;
   assign busy      = r_busy;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: transaction-level reference model checked every cycle plus directed literal expectations.
module tb_logic_unit_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int IDW  = 2;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [3*NREQ-1:0] op;
   logic [W*NREQ-1:0] a;
   logic [W*NREQ-1:0] b;
   logic [NREQ-1:0]   gnt;
   logic [W-1:0]      res;
   logic              res_valid;
   logic [IDW-1:0]    res_id;
   logic              res_err;
   logic              busy;

   int errors = 0;
   int checks = 0;

   logic_unit_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
      .gnt(gnt), .res(res), .res_valid(res_valid), .res_id(res_id),
      .res_err(res_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a transaction takes three cycles (grant, result, recovery).
   function automatic logic [7:0] f_ref(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      case (o)
         3'd0: return ~x;
         3'd1: return x | y;
         3'd2: return x & y;
         3'd3: return ~(x & y);
         3'd4: return ~(x | y);
         3'd5: return x ^ y;
         3'd6: return ~(x ^ y);
         default: return 8'h00;
      endcase
   endfunction

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   int              m_phase;
   int              m_ptr;
   int              m_win;
   logic [2:0]      m_op;
   logic [7:0]      m_a, m_b;
   logic [NREQ-1:0] e_gnt;
   logic [7:0]      e_res;
   logic            e_vld, e_err, e_busy;
   logic [IDW-1:0]  e_id;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= 0; m_ptr <= 0; m_win <= 0;
         m_op <= '0; m_a <= '0; m_b <= '0;
         e_gnt <= '0; e_res <= '0; e_vld <= 1'b0; e_err <= 1'b0;
         e_busy <= 1'b0; e_id <= '0;
      end else if (m_phase == 0) begin
         if (req != '0) begin
            m_win   <= rr_pick(req, m_ptr);
            m_op    <= op[3*rr_pick(req, m_ptr) +: 3];
            m_a     <= a[8*rr_pick(req, m_ptr) +: 8];
            m_b     <= b[8*rr_pick(req, m_ptr) +: 8];
            e_gnt   <= NREQ'(1) << rr_pick(req, m_ptr);
            e_busy  <= 1'b1;
            m_phase <= 1;
         end
      end else if (m_phase == 1) begin
         e_gnt   <= '0;
         e_res   <= f_ref(m_op, m_a, m_b);
         e_err   <= (m_op == 3'd7);
         e_vld   <= 1'b1;
         e_id    <= IDW'(m_win);
         m_phase <= 2;
      end else begin
         e_vld   <= 1'b0;
         e_busy  <= 1'b0;
         m_ptr   <= (m_win + 1) % NREQ;
         m_phase <= 0;
      end
   end

   always @(negedge clk) begin
      chk("m_gnt", 32'(gnt), 32'(e_gnt));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_res_valid", 32'(res_valid), 32'(e_vld));
      chk("m_res", 32'(res), 32'(e_res));
      chk("m_res_id", 32'(res_id), 32'(e_id));
      chk("m_res_err", 32'(res_err), 32'(e_err));
   end

   task automatic set_req(input int id, input logic [2:0] opc, input logic [7:0] av, input logic [7:0] bv);
      op[3*id +: 3] = opc;
      a[8*id +: 8]  = av;
      b[8*id +: 8]  = bv;
      req[id]       = 1'b1;
   endtask

   task automatic wait_gnt(input int id, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (gnt[id]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_op(input int id, input logic [2:0] opc, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] er, input logic ee);
      bit ok;
      set_req(id, opc, av, bv);
      wait_gnt(id, ok);
      if (ok) begin
         chk("op_gnt", 32'(gnt), 32'(NREQ'(1) << id));
         req[id] = 1'b0;
         @(posedge clk); #1;
         chk("op_valid", 32'(res_valid), 32'd1);
         chk("op_res", 32'(res), 32'(er));
         chk("op_id", 32'(res_id), 32'(id));
         chk("op_err", 32'(res_err), 32'(ee));
         @(posedge clk); #1;
         chk("op_busy_fall", 32'(busy), 32'd0);
         chk("op_res_hold", 32'(res), 32'(er));
      end
      req[id] = 1'b0;
   endtask

   localparam logic [8*8-1:0] TT_EXP = {8'h00, 8'hC3, 8'h3C, 8'hC0, 8'hFC, 8'h03, 8'h3F, 8'hF0};

   initial begin
      bit ok;
      int cyc, last, ng, pend;
      int seq [5];
      logic [8*8-1:0] tt;
      seq = '{0, 1, 2, 3, 0};
      tt  = TT_EXP;
      rst = 1'b1; req = '0; op = '0; a = '0; b = '0;
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(res_valid), 32'd0);
      #12 rst = 1'b0;

      // Reset asserted mid-run with random traffic.
      @(posedge clk); #1;
      req = NREQ'($urandom); op = 12'($urandom); a = $urandom; b = $urandom;
      repeat (2) @(posedge clk);
      #4 rst = 1'b1;
      #1;
      chk("arst_gnt", 32'(gnt), 32'd0);
      chk("arst_res", 32'(res), 32'd0);
      chk("arst_valid", 32'(res_valid), 32'd0);
      chk("arst_id", 32'(res_id), 32'd0);
      chk("arst_err", 32'(res_err), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      req = '0; op = '0; a = '0; b = '0;
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk("arst_busy_after", 32'(busy), 32'd0);

      // Fairness with every requester asserting continuously.
      for (int i = 0; i < NREQ; i++) set_req(i, 3'd1, 8'(8'h10 * i), 8'(i));
      cyc = 0; last = 0; ng = 0; pend = -1;
      while (ng < 5 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (pend >= 0) begin
            chk("fair_valid", 32'(res_valid), 32'd1);
            chk("fair_id", 32'(res_id), 32'(pend));
            pend = -1;
         end
         if (gnt != '0) begin
            chk("fair_gnt", 32'(gnt), 32'(NREQ'(1) << seq[ng]));
            if (ng > 0) chk("fair_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            pend = seq[ng];
            ng++;
         end
      end
      req = '0;
      if (ng < 5) chk("fair_timeout", 32'(ng), 32'd5);
      @(posedge clk); #1;
      if (pend >= 0) chk("fair_id_last", 32'(res_id), 32'(pend));
      repeat (2) @(posedge clk);
      #1;

      // Single request.
      do_op(1, 3'd2, 8'hF0, 8'hCC, 8'hC0, 1'b0);

      // Full truth table on requester 0.
      for (int o = 0; o < 8; o++)
         do_op(0, 3'(o), 8'h0F, 8'h33, tt[8*o +: 8], (o == 7));

      // Operands change right after the grant.
      set_req(2, 3'd5, 8'hAA, 8'h0F);
      wait_gnt(2, ok);
      req = '0; a[16 +: 8] = 8'hFF; b[16 +: 8] = 8'hFF; op[6 +: 3] = 3'd2;
      if (ok) begin
         @(posedge clk); #1;
         chk("stab_valid", 32'(res_valid), 32'd1);
         chk("stab_res", 32'(res), 32'h0000_00A5);
      end
      repeat (2) @(posedge clk);
      #1;

      // Reset during EXEC discards the transaction and rewinds the pointer.
      set_req(1, 3'd1, 8'h01, 8'h02);
      wait_gnt(1, ok);
      req = '0;
      #2 rst = 1'b1;
      #1;
      chk("xrst_gnt", 32'(gnt), 32'd0);
      chk("xrst_busy", 32'(busy), 32'd0);
      #3 rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         chk("xrst_no_valid", 32'(res_valid), 32'd0);
      end
      req = 4'b1100;
      op[6 +: 3] = 3'd2; a[16 +: 8] = 8'h3C; b[16 +: 8] = 8'h0F;
      wait_gnt(2, ok);
      chk("xrst_ptr_gnt", 32'(gnt), 32'h0000_0004);
      req = '0;
      if (ok) begin
         @(posedge clk); #1;
         chk("xrst_res", 32'(res), 32'h0000_000C);
         chk("xrst_id", 32'(res_id), 32'd2);
      end
      repeat (3) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
